// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Holds the scanner state enum, the keypad geometry, the key-code width and
// a helper that picks the lowest-numbered active (low) row.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 4;
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int ROW_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  // Rows are active-low. Walking downward lets the lowest-numbered low row win.
  // The result is only meaningful when at least one row is low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [ROW_W-1:0] low;
    low = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) low = ROW_W'(r);
    end
    return low;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-rate prescaler.
// Counts 0..TICK_DIV-1 on clk and raises tick for the single cycle in which
// the count sits at TICK_DIV-1. tick is a clock enable, not a clock.
//   clk   : system clock
//   reset : asynchronous, active-high
//   tick  : one-cycle enable pulse every TICK_DIV clocks
module scan_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                CNT_W   = $clog2(TICK_DIV - 1) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with debounce and a one-entry output register.
// One column is driven low at a time; the rows are read back through a
// two-flop synchronizer. A press must be seen on DEBOUNCE consecutive ticks
// before it is accepted, and the key must read released for DEBOUNCE
// consecutive ticks before scanning resumes.
//   clk         : system clock
//   reset       : asynchronous, active-high
//   row_in      : keypad rows, active-low, asynchronous to clk
//   col_out     : keypad column drive, active-low, one-cold
//   key_code    : accepted key, row*4+col
//   key_valid   : key_code holds an unconsumed key
//   key_ready   : consumer takes key_code when key_valid is also high
//   overrun     : sticky, a key was dropped because the output was full
//   overrun_clr : synchronous clear of overrun (a same-cycle drop wins)
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int               DB_W   = $clog2(DEBOUNCE) + 1;
  localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE);

  logic                tick;
  logic [NUM_ROWS-1:0] row_sync_p0;
  logic [NUM_ROWS-1:0] row_sync_p1;
  logic [NUM_ROWS-1:0] rs;
  logic [ROW_W-1:0]    low_row;
  logic                any_low;

  state_t           state,    state_nx;
  logic [COL_W-1:0] col,      col_nx;
  logic [ROW_W-1:0] cand_row, cand_row_nx;
  logic [DB_W-1:0]  db_cnt,   db_cnt_nx;
  logic [DB_W-1:0]  rel_cnt,  rel_cnt_nx;
  logic             accept;
  logic             handshake;
  logic             load_key;
  logic [KEY_W-1:0] accept_code;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Stage p0 -> p1: row synchronizer, idles at all-released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sync_p0 <= '1;
      row_sync_p1 <= '1;
    end else begin
      row_sync_p0 <= row_in;
      row_sync_p1 <= row_sync_p0;
    end
  end

  assign rs      = row_sync_p1;
  assign any_low = ~&rs;
  assign low_row = lowest_low_row(rs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_SCAN;
      col      <= '0;
      cand_row <= '0;
      db_cnt   <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_nx;
      col      <= col_nx;
      cand_row <= cand_row_nx;
      db_cnt   <= db_cnt_nx;
      rel_cnt  <= rel_cnt_nx;
    end
  end

  // All transitions are gated by tick; the column only moves when the
  // scanner is idle or gives up on a key.
  always_comb begin
    state_nx    = state;
    col_nx      = col;
    cand_row_nx = cand_row;
    db_cnt_nx   = db_cnt;
    rel_cnt_nx  = rel_cnt;
    accept      = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (!any_low) begin
            col_nx = col + COL_W'(1);
          end else begin
            cand_row_nx = low_row;
            db_cnt_nx   = DB_W'(1);
            if (DEBOUNCE == 1) begin
              accept     = 1'b1;
              rel_cnt_nx = '0;
              state_nx   = ST_RELEASE;
            end else begin
              state_nx = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (any_low && (low_row == cand_row)) begin
            db_cnt_nx = db_cnt + DB_W'(1);
            if (db_cnt + DB_W'(1) == DB_MAX) begin
              accept     = 1'b1;
              rel_cnt_nx = '0;
              state_nx   = ST_RELEASE;
            end
          end else begin
            db_cnt_nx = '0;
            col_nx    = col + COL_W'(1);
            state_nx  = ST_SCAN;
          end
        end
        ST_RELEASE: begin
          if (rs[cand_row]) begin
            if (rel_cnt + DB_W'(1) == DB_MAX) begin
              rel_cnt_nx = '0;
              db_cnt_nx  = '0;
              col_nx     = col + COL_W'(1);
              state_nx   = ST_SCAN;
            end else begin
              rel_cnt_nx = rel_cnt + DB_W'(1);
            end
          end else begin
            rel_cnt_nx = '0;
          end
        end
        default: begin
          state_nx = ST_SCAN;
        end
      endcase
    end
  end

  // A slot freed by a same-cycle handshake can take the new key immediately.
  assign handshake   = key_valid & key_ready;
  assign load_key    = accept & (~key_valid | handshake);
  assign accept_code = {cand_row_nx, col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_key) begin
        key_code  <= accept_code;
        key_valid <= 1'b1;
      end else if (handshake) begin
        key_valid <= 1'b0;
      end
      if (accept && !load_key) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign col_out = ~(NUM_COLS'(1) << col);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with TICK_DIV=4, DEBOUNCE=3. A behavioural
// keypad pulls a row low whenever a pressed key sits on the driven column;
// expected key codes are queued when a press starts and compared when the
// scanner presents a key.
module tb_keypad_scan_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       overrun;
  logic       overrun_clr = 1'b0;

  logic [15:0] pressed = '0;
  logic [3:0]  row_glitch = 4'hF;
  logic [3:0]  model_rows;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_q[$];

  keypad_scan_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    model_rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) model_rows[r] = 1'b0;
      end
    end
  end

  assign row_in = model_rows & row_glitch;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for a fresh arrival of column pattern v.
  task automatic wait_col(input logic [3:0] v, input string tag);
    int n;
    n = 0;
    while (col_out == v && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (col_out != v && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (col_out != v) check_eq({tag, "_timeout"}, int'(col_out), int'(v));
  endtask

  task automatic wait_change(input logic [3:0] prev, input string tag);
    int n;
    n = 0;
    while (col_out == prev && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (col_out == prev) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!key_valid) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ovr(input string tag);
    int n;
    n = 0;
    while (!overrun && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!overrun) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, int'(key_code), e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         t0;
    logic [3:0] prev;
    logic [3:0] seq [4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    repeat (3) @(negedge clk);
    check_eq("rst_col_out", int'(col_out), 4'b1110);
    check_eq("rst_key_valid", int'(key_valid), 0);
    check_eq("rst_key_code", int'(key_code), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // Idle scan: one column step every TICK_DIV clocks.
    reset = 1'b0;
    t0 = cyc;
    check_eq("scan_start_col", int'(col_out), 4'b1110);
    for (int i = 0; i < 4; i++) begin
      prev = col_out;
      wait_change(prev, "scan");
      check_eq("scan_col", int'(col_out), int'(seq[i]));
      check_eq("scan_period", cyc - t0, TICK_DIV);
      check_eq("scan_no_key", int'(key_valid), 0);
      t0 = cyc;
    end

    // Key 9: row2 on col1, accepted on the third matching tick.
    pressed = 16'h1 << 9;
    exp_q.push_back(9);
    wait_col(4'b1101, "k9_col");
    t0 = cyc;
    wait_valid("k9");
    check_eq("k9_latency", cyc - t0, DEBOUNCE * TICK_DIV);
    pop_check("k9_code");
    repeat (8) @(negedge clk);
    check_eq("k9_hold_valid", int'(key_valid), 1);
    check_eq("k9_hold_code", int'(key_code), 9);
    pressed = '0;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_eq("k9_consumed", int'(key_valid), 0);
    repeat (40) @(negedge clk);

    // One-tick glitch on row0 while col2 is driven.
    wait_col(4'b1011, "glitch_col");
    t0 = cyc;
    row_glitch = 4'b1110;
    repeat (5) @(negedge clk);
    row_glitch = 4'hF;
    wait_change(4'b1011, "glitch");
    check_eq("glitch_next_col", int'(col_out), 4'b0111);
    check_eq("glitch_abort_time", cyc - t0, 2 * TICK_DIV);
    check_eq("glitch_no_key", int'(key_valid), 0);

    // Key 5 left pending, then key 10 overruns.
    pressed = 16'h1 << 5;
    exp_q.push_back(5);
    wait_valid("k5");
    pop_check("k5_code");
    pressed = '0;
    repeat (40) @(negedge clk);
    pressed = 16'h1 << 10;
    wait_ovr("k10");
    check_eq("ovr_flag", int'(overrun), 1);
    check_eq("ovr_code_kept", int'(key_code), 5);
    check_eq("ovr_valid_kept", int'(key_valid), 1);
    pressed = '0;
    repeat (40) @(negedge clk);
    check_eq("ovr_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check_eq("ovr_cleared", int'(overrun), 0);
    check_eq("ovr_clr_code", int'(key_code), 5);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_eq("k5_consumed", int'(key_valid), 0);
    repeat (8) @(negedge clk);

    // Rows 1 and 3 on col0: lowest row wins.
    pressed = (16'h1 << 4) | (16'h1 << 12);
    exp_q.push_back(4);
    wait_valid("k4");
    pop_check("k4_code");
    pressed = '0;
    repeat (40) @(negedge clk);

    // Reset mid-debounce with key 4 still pending.
    wait_col(4'b1110, "rst_col0");
    pressed = 16'h1 << 6;
    wait_col(4'b1011, "rst_col2");
    repeat (6) @(negedge clk);
    check_eq("pre_rst_pending", int'(key_valid), 1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_col", int'(col_out), 4'b1110);
    check_eq("async_rst_valid", int'(key_valid), 0);
    check_eq("async_rst_ovr", int'(overrun), 0);
    check_eq("async_rst_code", int'(key_code), 0);
    repeat (2) @(negedge clk);
    pressed = '0;
    reset = 1'b0;
    t0 = cyc;
    check_eq("post_rst_col", int'(col_out), 4'b1110);
    wait_change(4'b1110, "post_rst");
    check_eq("post_rst_next_col", int'(col_out), 4'b1101);
    check_eq("post_rst_period", cyc - t0, TICK_DIV);
    check_eq("post_rst_no_key", int'(key_valid), 0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, clk cycles per scan tick; legal values are 4 or more.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, consecutive ticks needed to accept a press or a release; legal values are 1 or more.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row_in  input  4  keypad rows, active-low (pulled up), asynchronous to clk.
REQ-006 col_out  output  4  keypad column drive, active-low, one-cold.
REQ-007 key_code  output  4  accepted key, encoded row*4+col.
REQ-008 key_valid  output  1  key_code holds an unconsumed key.
REQ-009 key_ready  input  1  consumer accepts key_code when key_valid is also 1.
REQ-010 overrun  output  1  sticky flag: a key was dropped because the output was occupied.
REQ-011 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and pulse an internal tick for one clk when at TICK_DIV-1. No derived clock SHALL be generated.
REQ-013 row_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rs.
REQ-014 The FSM states SHALL be SCAN, DEBOUNCE and RELEASE; the FSM SHALL change state only on tick cycles.
REQ-015 col_out SHALL equal ~(1<<col) for column index col (0..3) in every state.
REQ-016 SCAN, on tick, when rs is all ones: col SHALL advance by 1 mod 4 (3 wraps to 0).
REQ-017 SCAN, on tick, when any rs bit is 0: the block SHALL capture cand_row, the lowest-numbered low row; set cnt=1; and hold col.
REQ-018 If DEBOUNCE=1, the key SHALL be accepted on the tick in REQ-017 and the FSM SHALL go to RELEASE; otherwise it SHALL go to DEBOUNCE.
REQ-019 DEBOUNCE, on tick: if cand_row is still the lowest low row, cnt SHALL increment, and on reaching DEBOUNCE the key SHALL be accepted and the FSM SHALL go to RELEASE.
REQ-020 DEBOUNCE, on tick, on mismatch: the FSM SHALL return to SCAN with col advanced by 1 mod 4, and no key SHALL be produced.
REQ-021 Key acceptance: if key_valid is 0, or a handshake occurs in the same cycle, the block SHALL load key_code=cand_row*4+col and set key_valid=1.
REQ-022 Key acceptance when key_valid is 1 and key_ready is 0: the new key SHALL be dropped, key_code SHALL be unchanged, and overrun SHALL be set to 1.
REQ-023 Handshake: on a clk with key_valid=1 and key_ready=1, key_valid SHALL clear the next cycle unless a new key is loaded in that same cycle.
REQ-024 While key_valid=1, key_code SHALL NOT change except through REQ-021.
REQ-025 RELEASE, on tick: if rs[cand_row]=1, the release count SHALL increment; if rs[cand_row]=0, it SHALL reset to 0.
REQ-026 RELEASE: when the release count reaches DEBOUNCE, the FSM SHALL go to SCAN with col advanced by 1 mod 4.
REQ-027 When overrun_clr and an overrun event occur in the same cycle, the event SHALL win and overrun SHALL stay 1.
REQ-028 Counter widths SHALL be $clog2 of their maximum value plus 1; no counter SHALL overflow for any legal parameter.

Reset
REQ-029 On reset assertion the block SHALL, immediately and independent of clk, set: state=SCAN, col=0 (col_out=4'b1110), key_code=0, key_valid=0, overrun=0, all counters=0, synchronizer flops=4'b1111.
REQ-030 Reset asserted in any state, mid-debounce or with a key pending, SHALL discard all in-progress and pending data.

Structure
REQ-031 Package keypad_pkg SHALL hold the state enum, the column count (4), the row count (4) and the key-code width (4).
REQ-032 The prescaler SHALL be a sub-module, scan_tick_gen (parameter TICK_DIV, output tick); the FSM and output register SHALL stay in keypad_scan_ctrl.

Verification (TICK_DIV=4, DEBOUNCE=3)
REQ-033 Reset release, no keys -> col_out cycles 1110, 1101, 1011, 0111, 1110, one step every 4 clk; key_valid=0 throughout.
REQ-034 Hold row2 low while col1 is driven, key_ready=0 -> key_code=9 and key_valid=1 after the 3rd matching tick and held stable; pulse key_ready for 1 clk -> key_valid=0 the next clk.
REQ-035 row0 low for 1 tick on col2 then high -> no key_valid; the next driven column is col3 (col_out=0111).
REQ-036 Press and release key 5, leave it unconsumed, then press key 10 -> key_code stays 5 and overrun=1; pulse overrun_clr -> overrun=0.
REQ-037 rows 1 and 3 low on col0 -> key_code=4.
REQ-038 Assert reset during DEBOUNCE -> same cycle col_out=1110, key_valid=0, overrun=0; scanning restarts from col0 after release.
